// File: rtl/sysarr_ctrl.sv
// Sequencer for the 3x3 systolic multiplier: feeds the skewed A/B wavefronts,
// captures the diagonal C outputs and returns the product over valid/ready.
module sysarr_ctrl #(
  parameter int DW    = 32,
  parameter int FLUSH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [9*DW-1:0] a_mat,
  input  logic [9*DW-1:0] b_mat,
  output logic [DW-1:0]   a00, a10, a20, a30, a40,
  output logic [DW-1:0]   b00, b01, b02, b03, b04,
  output logic [DW-1:0]   c00, c01, c02, c10, c20,
  input  logic [DW-1:0]   c53, c54, c55, c35, c45,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [9*DW-1:0] res_mat,
  output logic            busy
);

  localparam int FW = (FLUSH < 2) ? 1 : $clog2(FLUSH);
  localparam logic [FW-1:0] FLAST = FW'(FLUSH - 1);

  typedef enum logic [2:0] {IDLE, FEED, CAPT, RESP, FLSH} state_t;

  state_t                state, nstate;
  logic [3:0]            tc;      // index of the upcoming edge, relative to accept
  logic [FW-1:0]         fcnt;
  logic [8:0][DW-1:0]    a_q, b_q, a_src, b_src, res_q;
  logic [4:0][DW-1:0]    la, lb, la_n, lb_n;
  logic                  accept, load;
  logic [1:0]            k;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = start_valid && (state == IDLE);
  // on the accept edge the operand registers are not loaded yet, so use the ports
  assign a_src       = accept ? a_mat : a_q;
  assign b_src       = accept ? b_mat : b_q;
  assign load        = accept || (state == FEED && tc < 4'd3);
  assign k           = accept ? 2'd0 : tc[1:0];

  assign {a40, a30, a20, a10, a00} = la;
  assign {b04, b03, b02, b01, b00} = lb;
  assign {c00, c01, c02, c10, c20} = '0;
  assign res_mat = res_q;

  // wavefront k: A lanes carry row k of A, B lanes carry column k of B, skewed by k
  always_comb begin
    la_n = '0;
    lb_n = '0;
    if (load) begin
      for (int l = 0; l < 5; l++) begin
        for (int m = 0; m < 3; m++) begin
          if (l == int'(k) + m) begin
            la_n[l] = a_src[3*int'(k) + m];
            lb_n[l] = b_src[3*m + int'(k)];
          end
        end
      end
    end
  end

  // state register; reset lands in FLUSH so the array is drained before first use
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FLSH;
    else       state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (accept)         nstate = FEED;
      FEED: if (tc == 4'd5)     nstate = CAPT;
      CAPT: if (tc == 4'd8)     nstate = RESP;
      RESP: if (res_ready)      nstate = FLSH;
      FLSH: if (fcnt == FLAST)  nstate = IDLE;
      default:                  nstate = FLSH;
    endcase
  end

  // lanes, operand latch, edge counter, result capture and flush counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      la        <= '0;
      lb        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tc        <= '0;
      fcnt      <= '0;
      res_q     <= '0;
      res_valid <= 1'b0;
    end else begin
      la <= la_n;
      lb <= lb_n;
      if (accept) begin
        a_q <= a_mat;
        b_q <= b_mat;
        tc  <= 4'd1;
      end else if (state == FEED || state == CAPT) begin
        tc <= tc + 4'd1;
      end
      if (state == CAPT) begin
        case (tc)
          4'd6: begin
            res_q[0] <= c55;
            res_q[1] <= c45;
            res_q[2] <= c35;
            res_q[3] <= c54;
            res_q[6] <= c53;
          end
          4'd7: begin
            res_q[4] <= c55;
            res_q[5] <= c45;
            res_q[7] <= c54;
          end
          4'd8: begin
            res_q[8]  <= c55;
            res_valid <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state == RESP && res_ready) res_valid <= 1'b0;
      if (state == FLSH) fcnt <= (fcnt == FLAST) ? '0 : fcnt + 1'b1;
      else               fcnt <= '0;
    end
  end

endmodule

// File: tb/tb_sysarr_ctrl.sv
// Bench for sysarr_ctrl: a behavioural array model rebuilds the operands from the
// observed wavefronts and answers on the C diagonal; a scoreboard checks the products.
module tb_sysarr_ctrl;
  localparam int DW = 32;
  localparam int FLUSH = 4;

  typedef logic [8:0][31:0] mat_t;
  typedef logic [4:0][31:0] lane_t;

  logic clock, reset, start_valid, start_ready, res_valid, res_ready, busy;
  logic [9*DW-1:0] a_mat, b_mat, res_mat;
  logic [DW-1:0] a00, a10, a20, a30, a40, b00, b01, b02, b03, b04;
  logic [DW-1:0] c00, c01, c02, c10, c20, c53, c54, c55, c35, c45;

  sysarr_ctrl #(.DW(DW), .FLUSH(FLUSH)) dut (
    .clock(clock), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .a_mat(a_mat), .b_mat(b_mat),
    .a00(a00), .a10(a10), .a20(a20), .a30(a30), .a40(a40),
    .b00(b00), .b01(b01), .b02(b02), .b03(b03), .b04(b04),
    .c00(c00), .c01(c01), .c02(c02), .c10(c10), .c20(c20),
    .c53(c53), .c54(c54), .c55(c55), .c35(c35), .c45(c45),
    .res_valid(res_valid), .res_ready(res_ready), .res_mat(res_mat), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  lane_t la, lb;
  assign la = {a40, a30, a20, a10, a00};
  assign lb = {b04, b03, b02, b01, b00};

  int total = 0;
  int bad = 0;
  mat_t expq[$];
  time ta;

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t r;
    logic [31:0] s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = '0;
        for (int q = 0; q < 3; q++) s = s + a[3*i+q] * b[3*q+j];
        r[3*i+j] = s;
      end
    return r;
  endfunction

  function automatic mat_t seq_m();
    mat_t r;
    for (int i = 0; i < 9; i++) r[i] = 32'(i + 1);
    return r;
  endfunction

  function automatic mat_t diag_m(input logic [31:0] d);
    mat_t r;
    r = '0;
    for (int i = 0; i < 3; i++) r[4*i] = d;
    return r;
  endfunction

  // array model: operands reconstructed from lanes, results driven only in capture windows
  mat_t ma, mb, mc;
  int mt;
  bit mact;
  lane_t rnd;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mact <= 1'b0;
      mt   <= 0;
      ma   <= '0;
      mb   <= '0;
    end else begin
      for (int i = 0; i < 5; i++) rnd[i] <= $urandom;
      if (start_valid && start_ready) begin
        mact <= 1'b1;
        mt   <= 0;
      end else if (mact) begin
        mt <= mt + 1;
      end
      if (mact && mt <= 2)
        for (int m = 0; m < 3; m++) begin
          ma[3*mt+m] <= la[mt+m];
          mb[3*m+mt] <= lb[mt+m];
        end
    end
  end

  always_comb begin
    mc  = matmul(ma, mb);
    c55 = rnd[0];
    c45 = rnd[1];
    c35 = rnd[2];
    c54 = rnd[3];
    c53 = rnd[4];
    if (mact && mt == 5) begin
      c55 = mc[0]; c45 = mc[1]; c35 = mc[2]; c54 = mc[3]; c53 = mc[6];
    end else if (mact && mt == 6) begin
      c55 = mc[4]; c45 = mc[5]; c54 = mc[7];
    end else if (mact && mt == 7) begin
      c55 = mc[8];
    end
  end

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input mat_t a, input mat_t b, input bit hold);
    int n;
    a_mat = a;
    b_mat = b;
    start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("accept_rdy", 320'(start_ready), 320'(1));
    expq.push_back(matmul(a, b));
    @(posedge clock);
    ta = $time;
    #1;
    a_mat = {9{$urandom}};
    b_mat = {9{$urandom}};
    if (!hold) start_valid = 1'b0;
  endtask

  // expects res_ready=1; result is compared just before its handshake edge
  task automatic get_res(input string tag, input bit chk_lat);
    int n;
    mat_t e;
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_valid"}, 320'(res_valid), 320'(1));
    if (chk_lat) chk({tag, "_lat"}, 320'(($time + 5 - ta) / 10), 320'(9));
    e = (expq.size() > 0) ? expq.pop_front() : 'x;
    chk(tag, 320'(res_mat), 320'(e));
    @(posedge clock);
    #1;
    chk({tag, "_clr"}, 320'({res_valid, start_ready}), 320'(0));
  endtask

  mat_t sqc, negb, snap, rm;
  time ta1, ta2;

  initial begin
    int n;
    reset = 1'b1;
    start_valid = 1'b0;
    res_ready = 1'b1;
    a_mat = '0;
    b_mat = '0;
    sqc = {32'd150, 32'd126, 32'd102, 32'd96, 32'd81, 32'd66, 32'd42, 32'd36, 32'd30};

    // reset state
    #12;
    chk("rst_lanes", {la, lb}, 320'(0));
    chk("rst_res", 320'(res_mat), 320'(0));
    chk("rst_ctl", 320'({res_valid, start_ready, busy}), 320'(3'b001));
    @(negedge clock);
    reset = 1'b0;
    #1;
    n = 0;
    while (!start_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("rst_flush", 320'(n), 320'(FLUSH));

    // A=B=[1..9]
    @(negedge clock);
    do_start(seq_m(), seq_m(), 1'b0);
    get_res("sq", 1'b1);
    chk("sq_const", 320'(res_mat), 320'(sqc));
    chk("flush_busy", 320'({start_ready, busy}), 320'(2'b01));

    // B=identity, check the skewed lanes
    @(negedge clock);
    do_start(seq_m(), diag_m(32'd1), 1'b0);
    @(posedge clock);
    #1;
    chk("lane_a_t1", 320'(la), 320'(lane_t'({32'd0, 32'd6, 32'd5, 32'd4, 32'd0})));
    chk("lane_b_t1", 320'(lb), 320'(lane_t'({32'd0, 32'd0, 32'd1, 32'd0, 32'd0})));
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("lanes_t3", {la, lb}, 320'(0));
    get_res("ident", 1'b1);
    chk("ident_eq_a", 320'(res_mat), 320'(seq_m()));

    // back-pressure: hold result for 10 cycles
    res_ready = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 9; i++) rm[i] = $urandom;
    do_start(rm, seq_m(), 1'b0);
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    snap = res_mat;
    repeat (10) begin
      @(negedge clock);
      chk("hold_mat", 320'(res_mat), 320'(snap));
      chk("hold_ctl", 320'({res_valid, start_ready}), 320'(2'b10));
      chk("hold_lanes", {la, lb}, 320'(0));
    end
    res_ready = 1'b1;
    get_res("hold", 1'b0);

    // start_valid held across two ops; operand changes after accept ignored
    @(negedge clock);
    do_start(seq_m(), seq_m(), 1'b1);
    ta1 = ta;
    a_mat = diag_m(32'd1);
    b_mat = diag_m(32'd1);
    get_res("b2b1", 1'b1);
    n = 0;
    while (!start_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    expq.push_back(diag_m(32'd1));
    @(posedge clock);
    ta2 = $time;
    ta = ta2;
    #1;
    start_valid = 1'b0;
    chk("spacing", 320'((ta2 - ta1) / 10), 320'(10 + FLUSH));
    get_res("b2b2", 1'b1);

    // reset in the middle of an op
    @(negedge clock);
    do_start(seq_m(), diag_m(32'd1), 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_lanes", {la, lb}, 320'(0));
    chk("mid_rst_ctl", 320'({res_valid, start_ready}), 320'(0));
    expq.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    n = 0;
    while (!start_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("mid_rst_flush", 320'(n), 320'(FLUSH));
    do_start(seq_m(), seq_m(), 1'b0);
    get_res("post_rst", 1'b1);
    chk("post_rst_const", 320'(res_mat), 320'(sqc));

    // A = -identity: result is -B modulo 2^32
    @(negedge clock);
    do_start(diag_m(32'hFFFF_FFFF), seq_m(), 1'b0);
    get_res("negi", 1'b1);
    for (int i = 0; i < 9; i++) negb[i] = 32'(0) - 32'(i + 1);
    chk("negi_const", 320'(res_mat), 320'(negb));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

endmodule
